// File: rtl/coin_entry_ctrl.sv
// coin_entry_ctrl: synchronises and debounces three raw coin buttons, encodes
// each accepted press into a 2-bit coin code and presents it to the vending FSM
// as a setup cycle followed by a held next strobe.
//
// Handshake: coin_in/next form the valid side toward the vending FSM. coin_in is
// stable one cycle before next rises and for as long as next is high. accept acts
// as ready but is sampled only in IDLE: a press seen while accept is low is
// rejected (one-cycle reject pulse), never queued, and dropping accept after the
// press has been taken does not abort the delivery.
module coin_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             btn_c,
    input  logic             accept,
    output logic [1:0]       coin_in,
    output logic             next,
    output logic             busy,
    output logic             reject,
    output logic [CNT_W-1:0] coin_count,
    output logic [1:0]       dbg_state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LOAD = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_STROBE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Button bit order throughout: [0]=a, [1]=b, [2]=c.
    logic [2:0]      w_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db_level;
    logic [2:0]      r_db_level_d;
    logic [DB_W-1:0] r_db_cnt [3];

    logic [2:0]      w_event;
    logic            w_any_event;
    logic            w_multi_event;
    logic [1:0]      w_code;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_coin;
    logic [1:0]      w_coin_nxt;
    logic            r_next;
    logic            w_next_nxt;
    logic            r_reject;
    logic            w_reject_nxt;
    logic [HD_W-1:0] r_hold;
    logic [HD_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_raw = {btn_c, btn_b, btn_a};

    // Two-flop synchronisers and per-button debounce counters/levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_db_level   <= '0;
            r_db_level_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1      <= w_raw;
            r_sync2      <= r_sync1;
            r_db_level_d <= r_db_level;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i]   <= '0;
                    r_db_level[i] <= ~r_db_level[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press events are debounced rising edges; more than one at once is ambiguous.
    assign w_event       = r_db_level & ~r_db_level_d;
    assign w_any_event   = |w_event;
    assign w_multi_event = (w_event[0] & w_event[1]) | (w_event[0] & w_event[2]) |
                           (w_event[1] & w_event[2]);
    assign w_code        = w_event[2] ? 2'b11 :
                           w_event[1] ? 2'b10 :
                           w_event[0] ? 2'b01 : 2'b00;

    // Next-state and next-output logic of the delivery FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_coin_nxt   = r_coin;
        w_hold_nxt   = r_hold;
        w_count_nxt  = r_count;
        w_reject_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_event) begin
                    if (w_multi_event || !accept) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_coin_nxt  = w_code;
                        w_state_nxt = S_PRESENT;
                    end
                end
            end
            S_PRESENT: begin
                w_state_nxt = S_STROBE;
                w_hold_nxt  = HD_LOAD;
                if (r_count != '1) begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            S_STROBE: begin
                if (r_hold == '0) begin
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_db_level == 3'b000) begin
                    w_coin_nxt  = 2'b00;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_coin_nxt  = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_next_nxt = (w_state_nxt == S_STROBE);
    end

    // State register plus registered coin, strobe, reject and counter outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_coin   <= 2'b00;
            r_next   <= 1'b0;
            r_reject <= 1'b0;
            r_hold   <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_coin   <= w_coin_nxt;
            r_next   <= w_next_nxt;
            r_reject <= w_reject_nxt;
            r_hold   <= w_hold_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign coin_in    = r_coin;
    assign next       = r_next;
    assign reject     = r_reject;
    assign coin_count = r_count;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_coin_entry_ctrl.sv
// Bench for coin_entry_ctrl: table of press scenarios plus hand-written
// sequences for held buttons across a delivery and asynchronous reset.
module tb_coin_entry_ctrl;

    localparam int TB_CNT_W  = 3;
    localparam int CNT_MAX   = 7;
    localparam int SETTLE    = 40;
    localparam int ST_RELEASE = 3;

    logic                clk;
    logic                reset;
    logic                btn_a;
    logic                btn_b;
    logic                btn_c;
    logic                accept;
    logic [1:0]          coin_in;
    logic                next;
    logic                busy;
    logic                reject;
    logic [TB_CNT_W-1:0] coin_count;
    logic [1:0]          dbg_state;

    coin_entry_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .HOLD_CYCLES    (4),
        .CNT_W          (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .btn_c     (btn_c),
        .accept    (accept),
        .coin_in   (coin_in),
        .next      (next),
        .busy      (busy),
        .reject    (reject),
        .coin_count(coin_count),
        .dbg_state (dbg_state)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btns;      // {c, b, a}
        logic       acc;
        int         hold;      // raw press length in cycles
        logic [1:0] exp_coin;
        int         exp_next;  // cycles next is high
        int         exp_rej;   // cycles reject is high
        int         exp_delta; // coins delivered
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_cnt = 0;

    // Monitor state, sampled on the falling edge
    int         m_rises;
    int         m_next_cyc;
    int         m_rej;
    int         m_chg;
    int         m_coin_nz;
    int         m_rise_cyc;
    logic [1:0] m_coin_before;
    logic [1:0] m_coin_at_rise;
    logic       m_prev_next;
    logic [1:0] m_prev_coin;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (case %0d): actual %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int idx, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s (case %0d): actual %0d expected %0d..%0d", name, idx, act, lo, hi);
        end
    endtask

    task automatic clear_mon();
        m_rises    = 0;
        m_next_cyc = 0;
        m_rej      = 0;
        m_chg      = 0;
        m_coin_nz  = 0;
        m_rise_cyc = -1;
        m_coin_before  = 2'b00;
        m_coin_at_rise = 2'b00;
    endtask

    // Driver: advance one cycle and update the monitor
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (next && !m_prev_next) begin
            m_rises++;
            if (m_rise_cyc < 0) begin
                m_rise_cyc     = cyc;
                m_coin_before  = m_prev_coin;
                m_coin_at_rise = coin_in;
            end
        end
        if (next) begin
            m_next_cyc++;
            if (m_prev_next && coin_in != m_prev_coin) m_chg++;
        end
        if (reject) m_rej++;
        if (coin_in != 2'b00) m_coin_nz++;
        m_prev_next = next;
        m_prev_coin = coin_in;
    endtask

    task automatic add_expected(input int delta);
        exp_cnt = (exp_cnt + delta > CNT_MAX) ? CNT_MAX : exp_cnt + delta;
    endtask

    // Driver: apply one scenario, let it settle, then score it
    task automatic run_vec(input vec_t v, input int idx);
        int c0;
        clear_mon();
        accept = v.acc;
        {btn_c, btn_b, btn_a} = v.btns;
        c0 = cyc;
        repeat (v.hold) tick();
        {btn_c, btn_b, btn_a} = 3'b000;
        repeat (SETTLE) tick();
        add_expected(v.exp_delta);
        chk("next_cycles", idx, m_next_cyc, v.exp_next);
        chk("reject_cycles", idx, m_rej, v.exp_rej);
        chk("coin_count", idx, int'(coin_count), exp_cnt);
        chk("busy_after", idx, int'(busy), 0);
        chk("coin_after", idx, int'(coin_in), 0);
        chk("coin_stable_in_next", idx, m_chg, 0);
        if (v.exp_next > 0) begin
            chk("next_rises", idx, m_rises, 1);
            chk("coin_setup", idx, int'(m_coin_before), int'(v.exp_coin));
            chk("coin_at_rise", idx, int'(m_coin_at_rise), int'(v.exp_coin));
            chk_rng("latency", idx, m_rise_cyc - c0, 19, 21);
        end else begin
            chk("coin_never_set", idx, m_coin_nz, 0);
        end
        accept = 1'b1;
    endtask

    initial begin
        int c0;

        //            btns    acc  hold coin   next rej delta
        vecs[0] = '{3'b010, 1'b1, 40, 2'b10, 4, 0, 1}; // clean btn_b
        vecs[1] = '{3'b001, 1'b1,  5, 2'b00, 0, 0, 0}; // 5-cycle glitch on a
        vecs[2] = '{3'b100, 1'b0, 40, 2'b00, 0, 1, 0}; // btn_c, accept low
        vecs[3] = '{3'b011, 1'b1, 40, 2'b00, 0, 1, 0}; // a+b together
        vecs[4] = '{3'b001, 1'b1, 40, 2'b01, 4, 0, 1}; // later clean btn_a
        vecs[5] = '{3'b001, 1'b1, 15, 2'b00, 0, 0, 0}; // one cycle short of debounce
        vecs[6] = '{3'b001, 1'b1, 16, 2'b01, 4, 0, 1}; // exactly debounce length
        vecs[7] = '{3'b100, 1'b1, 30, 2'b11, 4, 0, 1}; // clean btn_c

        reset  = 1'b1;
        btn_a  = 1'b0;
        btn_b  = 1'b0;
        btn_c  = 1'b0;
        accept = 1'b1;
        m_prev_next = 1'b0;
        m_prev_coin = 2'b00;
        clear_mon();

        repeat (3) tick();
        chk("rst_coin", 0, int'(coin_in), 0);
        chk("rst_next", 0, int'(next), 0);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_reject", 0, int'(reject), 0);
        chk("rst_count", 0, int'(coin_count), 0);
        chk("rst_state", 0, int'(dbg_state), 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // btn_c held through the delivery, btn_a pressed mid-strobe
        clear_mon();
        btn_c = 1'b1;
        repeat (21) tick();
        chk("held_strobe_active", 100, int'(next), 1);
        btn_a = 1'b1;
        repeat (39) tick();
        btn_c = 1'b0;
        repeat (22) tick();
        chk("held_busy_a_down", 100, int'(busy), 1);
        chk("held_state_release", 100, int'(dbg_state), ST_RELEASE);
        btn_a = 1'b0;
        repeat (30) tick();
        add_expected(1);
        chk("held_busy_end", 100, int'(busy), 0);
        chk("held_coin_end", 100, int'(coin_in), 0);
        chk("held_next_cycles", 100, m_next_cyc, 4);
        chk("held_rises", 100, m_rises, 1);
        chk("held_reject", 100, m_rej, 0);
        chk("held_count", 100, int'(coin_count), exp_cnt);

        // Drive the counter into saturation
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[6], 200 + i);
        end
        chk("count_saturated", 300, int'(coin_count), CNT_MAX);

        // Asynchronous reset during the second strobe cycle
        clear_mon();
        btn_b = 1'b1;
        c0 = cyc;
        repeat (21) tick();
        chk("pre_reset_next", 400, int'(next), 1);
        chk("pre_reset_coin", 400, int'(coin_in), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_next", 400, int'(next), 0);
        chk("async_coin", 400, int'(coin_in), 0);
        chk("async_count", 400, int'(coin_count), 0);
        chk("async_busy", 400, int'(busy), 0);
        btn_b = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        exp_cnt = 0;
        repeat (5) tick();
        run_vec(vecs[4], 401);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
